jtkcpu_busctrl: RTL and testbench

Parametrised bus sequencer for the KONAMI CPU core, the successor to the fixed 8/16-bit memory controller. It turns one request from the control unit into a big-endian burst of 1..MAXB byte accesses, inserts wait states on `mem_ok`, and fetches interrupt vectors. It sits between the control unit / address mux and the external 8-bit memory bus.

---
 rtl/jtkcpu_busctrl_pkg.sv | 19 +
 rtl/jtkcpu_busvec.sv | 23 ++
 rtl/jtkcpu_busctrl.sv | 173 +++++++++++++++++
 tb/tb_jtkcpu_busctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_busctrl_pkg.sv
// Shared definitions for the KONAMI CPU bus sequencer.
// Contents: bus FSM state encoding and the interrupt vector offsets that are
// added to the vector base address.
package jtkcpu_busctrl_pkg;

  localparam int unsigned VEC_OFS_W = 4;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_XFER = 2'd1,
    BUS_DONE = 2'd2
  } bus_state_e;

  localparam logic [VEC_OFS_W-1:0] FIRQ_OFS = 4'd0;
  localparam logic [VEC_OFS_W-1:0] IRQ_OFS  = 4'd2;
  localparam logic [VEC_OFS_W-1:0] NMI_OFS  = 4'd6;
  localparam logic [VEC_OFS_W-1:0] RST_OFS  = 4'd8;

endpackage

// File: rtl/jtkcpu_busvec.sv
// Interrupt vector priority encoder.
// Ports: req_vec {RST,NMI,FIRQ,IRQ} in; vec_ofs_c offset from the vector base,
// vec_valid_c high when any vector bit is set (both combinational).
module jtkcpu_busvec
  import jtkcpu_busctrl_pkg::*;
(
  input  logic [3:0]           req_vec,
  output logic [VEC_OFS_W-1:0] vec_ofs_c,
  output logic                 vec_valid_c
);

  // RST > NMI > FIRQ > IRQ
  always_comb begin
    vec_ofs_c   = FIRQ_OFS;
    vec_valid_c = 1'b1;
    if      (req_vec[3]) vec_ofs_c = RST_OFS;
    else if (req_vec[2]) vec_ofs_c = NMI_OFS;
    else if (req_vec[1]) vec_ofs_c = FIRQ_OFS;
    else if (req_vec[0]) vec_ofs_c = IRQ_OFS;
    else                 vec_valid_c = 1'b0;
  end

endmodule

// File: rtl/jtkcpu_busctrl.sv
// Bus sequencer: turns one control-unit request into a big-endian burst of
// 1..MAXB byte accesses on an 8-bit memory bus, with mem_ok wait states,
// halt freezing and interrupt vector fetches.
// Ports:
//   clk, rst_n (sync, active-low), cen (bus clock enable), halt (freeze)
//   req/req_we/req_op/req_len/req_addr/req_wdata/req_vec : request
//   busy, done, rdata, op                                 : status / results
//   addr, dout, din, rd, we, mem_ok                       : memory bus
module jtkcpu_busctrl
  import jtkcpu_busctrl_pkg::*;
#(
  parameter  int unsigned AW      = 16,
  parameter  int unsigned MAXB    = 2,
  parameter  logic [15:0] VECBASE = 16'hFFF6,
  localparam int unsigned LW      = (MAXB > 2) ? $clog2(MAXB) : 1,
  localparam int unsigned DW      = 8 * MAXB
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          halt,
  input  logic          req,
  input  logic          req_we,
  input  logic          req_op,
  input  logic [LW-1:0] req_len,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_vec,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [7:0]    op,
  output logic [AW-1:0] addr,
  output logic [7:0]    dout,
  input  logic [7:0]    din,
  output logic          rd,
  output logic          we,
  input  logic          mem_ok
);

  localparam logic [LW-1:0] VEC_LEN = (MAXB >= 2) ? LW'(1) : LW'(0);

  bus_state_e           state, state_nxt;
  logic                 busy_nxt, done_nxt, rd_nxt, we_nxt;
  logic [AW-1:0]        addr_nxt;
  logic [7:0]           dout_nxt, op_nxt;
  logic [DW-1:0]        rdata_nxt;
  logic [DW-1:0]        rsh, rsh_nxt;     // read accumulator, copied to rdata at the end
  logic [DW-1:0]        wsh, wsh_nxt;     // write data, next byte to send at the top
  logic [LW-1:0]        cnt, cnt_nxt;
  logic                 op_req, op_req_nxt;

  logic [VEC_OFS_W-1:0] vec_ofs_c;
  logic                 vec_valid_c;
  logic [AW-1:0]        vec_addr_c;
  logic [LW-1:0]        len_c;
  logic                 acc_we_c;
  logic [DW-1:0]        wsh_init_c, wsh_adv_c, rsh_adv_c;

  jtkcpu_busvec u_busvec (
    .req_vec     (req_vec),
    .vec_ofs_c   (vec_ofs_c),
    .vec_valid_c (vec_valid_c)
  );

  assign vec_addr_c = AW'(VECBASE) + AW'(vec_ofs_c);

  // Request decode: length, direction and left-justified write data
  always_comb begin
    if (vec_valid_c)                len_c = VEC_LEN;
    else if (req_op)                len_c = '0;
    else if (32'(req_len) >= MAXB)  len_c = LW'(MAXB - 1);
    else                            len_c = req_len;
    acc_we_c   = req_we & ~vec_valid_c & ~req_op;
    wsh_init_c = req_wdata << (8 * (MAXB - 1 - 32'(len_c)));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    busy_nxt   = busy;
    done_nxt   = done;
    rd_nxt     = rd;
    we_nxt     = we;
    addr_nxt   = addr;
    dout_nxt   = dout;
    op_nxt     = op;
    rdata_nxt  = rdata;
    rsh_nxt    = rsh;
    wsh_nxt    = wsh;
    cnt_nxt    = cnt;
    op_req_nxt = op_req;
    rsh_adv_c  = DW'({rsh, din});
    wsh_adv_c  = DW'({wsh, 8'h00});

    if (cen && !halt) begin
      unique case (state)
        BUS_IDLE: begin
          if (req) begin
            state_nxt  = BUS_XFER;
            busy_nxt   = 1'b1;
            rd_nxt     = ~acc_we_c;
            we_nxt     = acc_we_c;
            addr_nxt   = vec_valid_c ? vec_addr_c : req_addr;
            cnt_nxt    = len_c;
            wsh_nxt    = wsh_init_c;
            rsh_nxt    = '0;
            op_req_nxt = req_op & ~vec_valid_c;
            if (acc_we_c) dout_nxt = wsh_init_c[DW-1 -: 8];
          end
        end
        BUS_XFER: begin
          if (mem_ok) begin
            rsh_nxt = rsh_adv_c;
            if (op_req) op_nxt = din;
            if (cnt == '0) begin
              state_nxt = BUS_DONE;
              rd_nxt    = 1'b0;
              we_nxt    = 1'b0;
              done_nxt  = 1'b1;
              if (rd) rdata_nxt = rsh_adv_c;
            end else begin
              addr_nxt = addr + AW'(1);
              cnt_nxt  = cnt - LW'(1);
              wsh_nxt  = wsh_adv_c;
              if (we) dout_nxt = wsh_adv_c[DW-1 -: 8];
            end
          end
        end
        BUS_DONE: begin
          state_nxt = BUS_IDLE;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b0;
        end
        default: state_nxt = BUS_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BUS_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd     <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      dout   <= '0;
      op     <= '0;
      rdata  <= '0;
      rsh    <= '0;
      wsh    <= '0;
      cnt    <= '0;
      op_req <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      rd     <= rd_nxt;
      we     <= we_nxt;
      addr   <= addr_nxt;
      dout   <= dout_nxt;
      op     <= op_nxt;
      rdata  <= rdata_nxt;
      rsh    <= rsh_nxt;
      wsh    <= wsh_nxt;
      cnt    <= cnt_nxt;
      op_req <= op_req_nxt;
    end
  end

endmodule

// File: tb/tb_jtkcpu_busctrl.sv
// Self-checking bench for jtkcpu_busctrl (AW=16, MAXB=4): directed table,
// hand-written multi-cycle corner cases and randomized bursts against a
// burst-level reference model.
module tb_jtkcpu_busctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned MAXB = 4;
  localparam int unsigned LW = 2;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, cen, halt, req, req_we, req_op, mem_ok;
  logic [LW-1:0] req_len;
  logic [AW-1:0] req_addr, addr;
  logic [DW-1:0] req_wdata, rdata;
  logic [3:0]    req_vec;
  logic          busy, done, rd, we;
  logic [7:0]    op, dout, din;

  logic [7:0]    mem [0:65535];
  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   m_rdata;
  logic [7:0]    m_op;

  always #5 clk = ~clk;
  assign din = mem[addr];

  jtkcpu_busctrl #(.AW(AW), .MAXB(MAXB), .VECBASE(16'hFFF6)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .halt(halt), .req(req),
    .req_we(req_we), .req_op(req_op), .req_len(req_len), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_vec(req_vec), .busy(busy), .done(done),
    .rdata(rdata), .op(op), .addr(addr), .dout(dout), .din(din), .rd(rd),
    .we(we), .mem_ok(mem_ok)
  );

  typedef struct {
    logic        we;
    logic        op;
    logic [1:0]  len;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  vec;
    logic [15:0] exp_addr0;
    int          exp_ticks;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one cen tick: cen high across exactly one posedge, then one plain clk edge
  task automatic step();
    @(negedge clk) cen = 1'b1;
    @(negedge clk) cen = 1'b0;
  endtask

  function automatic logic [67:0] snap();
    return {busy, done, rd, we, addr, dout, rdata, op};
  endfunction

  function automatic logic [7:0] wbyte(input logic [31:0] d, input int n, input int k);
    return 8'(d >> (8 * (n - 1 - k)));
  endfunction

  // Issue one request and follow it to completion; returns the first address
  // seen and the number of cen ticks from acceptance to done.
  task automatic do_burst(input logic t_we, input logic t_op, input logic [1:0] t_len,
                          input logic [15:0] t_addr, input logic [31:0] t_wdata,
                          input logic [3:0] t_vec, input int halt_first, input int wait_first,
                          input int halt_pct, input int wait_pct,
                          output logic [15:0] o_addr0, output int o_ticks);
    int          n, i, ticks;
    logic [15:0] base, a;
    logic        is_wr;
    logic [31:0] exp_rd;
    logic [67:0] prev;
    if (t_vec != 4'd0) begin
      base  = t_vec[3] ? 16'hFFFE : t_vec[2] ? 16'hFFFC : t_vec[1] ? 16'hFFF6 : 16'hFFF8;
      n     = 2;
      is_wr = 1'b0;
    end else if (t_op) begin
      base = t_addr; n = 1; is_wr = 1'b0;
    end else begin
      base = t_addr; n = int'(t_len) + 1; is_wr = t_we;
    end
    exp_rd = '0;
    for (int k = 0; k < n; k++) begin
      a      = base + 16'(k);
      exp_rd = (exp_rd << 8) | 32'(mem[a]);
    end

    req = 1'b1; req_we = t_we; req_op = t_op; req_len = t_len; req_addr = t_addr;
    req_wdata = t_wdata; req_vec = t_vec; halt = 1'b0; mem_ok = 1'($urandom);
    step();
    o_addr0 = addr;
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    chk("acc_strobe", {rd, we}, is_wr ? 2'b01 : 2'b10);
    chk("acc_addr", addr, base);
    if (is_wr) chk("acc_dout", dout, wbyte(t_wdata, n, 0));

    i = 0; ticks = 0; o_ticks = -1;
    while (i < n && ticks < 200) begin
      prev = snap();
      if (ticks < halt_first) begin
        halt = 1'b1; mem_ok = 1'b1;
      end else if (ticks < halt_first + wait_first) begin
        halt = 1'b0; mem_ok = 1'b0;
      end else begin
        halt   = ($urandom_range(99) < 32'(halt_pct));
        mem_ok = ($urandom_range(99) >= 32'(wait_pct));
      end
      req = 1'($urandom); req_addr = 16'($urandom); req_vec = 4'($urandom);
      req_we = 1'($urandom);
      step();
      ticks++;
      if (halt) begin
        chk("halt_freeze", snap(), prev);
      end else if (!mem_ok) begin
        chk("wait_hold", snap(), prev);
      end else begin
        i++;
        if (i == n) begin
          o_ticks = ticks;
          if (!is_wr) m_rdata = exp_rd;
          if (t_op && t_vec == 4'd0) m_op = mem[base];
          chk("end_strobe", {rd, we}, 2'b00);
          chk("end_done", done, 1);
          chk("end_busy", busy, 1);
          chk("end_rdata", rdata, m_rdata);
          chk("end_op", op, m_op);
        end else begin
          a = base + 16'(i);
          chk("mid_addr", addr, a);
          chk("mid_strobe", {rd, we}, is_wr ? 2'b01 : 2'b10);
          chk("mid_done", done, 0);
          chk("mid_busy", busy, 1);
          chk("mid_rdata", rdata, m_rdata);
          if (is_wr) chk("mid_dout", dout, wbyte(t_wdata, n, i));
        end
      end
    end
    chk("burst_complete", i, n);
    halt = 1'b0;

    // a request during the done period must be ignored
    req = 1'b1; req_addr = 16'($urandom); req_vec = 4'd0; req_op = 1'b0; req_we = 1'b0;
    step();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_strobe", {rd, we}, 2'b00);
    req = 1'b0;
  endtask

  vec_t        tbl [8];
  logic [15:0] a0;
  int          tk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    mem[16'h1000] = 8'h12; mem[16'h1001] = 8'h34;
    mem[16'hFFFF] = 8'hA1; mem[16'h0000] = 8'hB2; mem[16'h0001] = 8'hC3;
    mem[16'hFFFC] = 8'h5A; mem[16'hFFFD] = 8'h5B;
    mem[16'hFFF6] = 8'h6A; mem[16'hFFF7] = 8'h6B;
    mem[16'hFFFE] = 8'h7E;
    mem[16'hFFF8] = 8'h81; mem[16'hFFF9] = 8'h82;
    mem[16'h0100] = 8'h3A;

    tbl[0] = '{1'b0, 1'b0, 2'd1, 16'h1000, 32'h0,        4'b0000, 16'h1000, 2, 32'h0000_1234};
    tbl[1] = '{1'b0, 1'b0, 2'd2, 16'hFFFF, 32'h0,        4'b0000, 16'hFFFF, 3, 32'h00A1_B2C3};
    tbl[2] = '{1'b0, 1'b0, 2'd3, 16'h4321, 32'h0,        4'b0101, 16'hFFFC, 2, 32'h0000_5A5B};
    tbl[3] = '{1'b1, 1'b0, 2'd0, 16'h4321, 32'h0,        4'b0010, 16'hFFF6, 2, 32'h0000_6A6B};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 16'h0100, 32'h0,        4'b0000, 16'h0100, 1, 32'h0000_003A};
    tbl[5] = '{1'b1, 1'b0, 2'd3, 16'h4000, 32'h11223344, 4'b0000, 16'h4000, 4, 32'h0000_003A};
    tbl[6] = '{1'b1, 1'b1, 2'd0, 16'h0200, 32'h0,        4'b1001, 16'hFFFE, 2, 32'h0000_7EA1};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 16'h0300, 32'h0,        4'b0001, 16'hFFF8, 2, 32'h0000_8182};

    rst_n = 1'b0; cen = 1'b0; halt = 1'b0; req = 1'b0; req_we = 1'b0; req_op = 1'b0;
    req_len = '0; req_addr = '0; req_wdata = '0; req_vec = '0; mem_ok = 1'b0;
    m_rdata = '0; m_op = '0;
    step(); step();
    chk("reset_state", snap(), 68'h0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      do_burst(tbl[t].we, tbl[t].op, tbl[t].len, tbl[t].addr, tbl[t].wdata, tbl[t].vec,
               0, 0, 0, 0, a0, tk);
      chk($sformatf("tbl%0d_addr0", t), a0, tbl[t].exp_addr0);
      chk($sformatf("tbl%0d_ticks", t), tk, tbl[t].exp_ticks);
      chk($sformatf("tbl%0d_rdata", t), rdata, tbl[t].exp_rdata);
    end
    chk("op_after_vec", op, 8'h3A);

    // write with three wait states: done four ticks after acceptance
    do_burst(1'b1, 1'b0, 2'd0, 16'h2000, 32'hA5, 4'd0, 0, 3, 0, 0, a0, tk);
    chk("wait_ticks", tk, 4);

    // halt for two ticks mid-access delays completion by two ticks
    do_burst(1'b0, 1'b0, 2'd1, 16'h1000, 32'h0, 4'd0, 2, 0, 0, 0, a0, tk);
    chk("halt_ticks", tk, 4);
    chk("halt_rdata", rdata, 32'h1234);

    // halted request in IDLE is not accepted
    halt = 1'b1; req = 1'b1; req_addr = 16'h1000; req_vec = 4'd0;
    step();
    chk("halt_idle_busy", busy, 0);
    halt = 1'b0; req = 1'b0;
    step();
    chk("idle_no_req", busy, 0);

    // reset after the first byte of a 2-byte read
    req = 1'b1; req_we = 1'b0; req_op = 1'b0; req_len = 2'd1; req_addr = 16'h1234;
    mem_ok = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("pre_reset_addr", addr, 16'h1235);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midburst_reset", snap(), 68'h0);
    @(negedge clk) rst_n = 1'b1;
    m_rdata = '0; m_op = '0;
    do_burst(1'b0, 1'b0, 2'd1, 16'h1000, 32'h0, 4'd0, 0, 0, 0, 0, a0, tk);
    chk("post_reset_rdata", rdata, 32'h1234);
    chk("post_reset_ticks", tk, 2);

    // randomized bursts with random waits and halts
    for (int r = 0; r < 40; r++) begin
      logic [3:0] rv;
      rv = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
      do_burst(1'($urandom), ($urandom_range(5) == 0), 2'($urandom), 16'($urandom),
               $urandom, rv, 0, 0, 10, 30, a0, tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
